byte_word_packer: RTL and testbench

// Packs a byte stream into WORD_BYTES-wide words, one byte per cycle in, one word out, with valid/ready on both sides.

---
 rtl/byte_pack_pkg.sv | 24 ++
 rtl/byte_word_packer.sv | 164 ++++++++++++++++
 tb/tb_byte_word_packer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/byte_pack_pkg.sv
// Shared constants, types and lane-mapping helper for the byte-to-word packer.
package byte_pack_pkg;

    localparam int BYTE_W         = 8;
    localparam int MAX_WORD_BYTES = 8;

    // Widest keep vector a packer instance can need; instances use the low WORD_BYTES bits.
    typedef logic [MAX_WORD_BYTES-1:0] keep_t;

    // Lane / byte index, wide enough for the largest legal word.
    typedef logic [2:0] lane_t;

    // Map the running byte index to its lane: MSB-first mirrors the index, LSB-first keeps it.
    function automatic lane_t lane_idx(input lane_t cnt, input logic big_endian, input lane_t last_lane);
        lane_t mirrored;
        mirrored = last_lane - cnt;
        if (big_endian) begin
            lane_idx = mirrored;
        end else begin
            lane_idx = cnt;
        end
    endfunction

endpackage

// File: rtl/byte_word_packer.sv
// Packs a valid/ready byte stream into WORD_BYTES-wide words with per-lane keep bits.
// A one-deep accumulator plus a registered output stage; when the output is stalled
// a completed word parks in the accumulator and input is back-pressured until it moves.
module byte_word_packer
    import byte_pack_pkg::*;
#(
    parameter int WORD_BYTES = 4,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [BYTE_W-1:0]            in_data_i,
    input  logic                         in_last_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [BYTE_W*WORD_BYTES-1:0] out_data_o,
    output logic [WORD_BYTES-1:0]        out_keep_o,
    output logic                         out_last_o
);

    localparam int              DATA_W   = BYTE_W * WORD_BYTES;
    localparam int              CNT_W    = $clog2(WORD_BYTES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_BYTES - 1);
    localparam lane_t           LAST_LANE = lane_t'(WORD_BYTES - 1);

    // Registered state
    logic [DATA_W-1:0]     acc_r;
    logic [WORD_BYTES-1:0] acc_keep_r;
    logic                  acc_last_r;
    logic                  acc_full_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [DATA_W-1:0]     out_data_r;
    logic [WORD_BYTES-1:0] out_keep_r;
    logic                  out_last_r;
    logic                  out_valid_r;
    logic                  in_ready_r;

    // Next-state and helper signals
    logic [DATA_W-1:0]     acc_s;
    logic [WORD_BYTES-1:0] acc_keep_s;
    logic                  acc_last_s;
    logic                  acc_full_s;
    logic [CNT_W-1:0]      cnt_s;
    logic [DATA_W-1:0]     out_data_s;
    logic [WORD_BYTES-1:0] out_keep_s;
    logic                  out_last_s;
    logic                  out_valid_s;
    logic                  accept_s;
    logic                  complete_s;
    logic                  drain_s;
    logic                  slot_free_s;
    lane_t                 lane_s;
    logic [WORD_BYTES-1:0] lane_hit_s;
    logic [DATA_W-1:0]     word_s;
    logic [WORD_BYTES-1:0] word_keep_s;

    assign in_ready_o  = in_ready_r;
    assign out_valid_o = out_valid_r;
    assign out_data_o  = out_data_r;
    assign out_keep_o  = out_keep_r;
    assign out_last_o  = out_last_r;

    // Handshake qualifiers and the lane selected by the current byte count.
    always_comb begin
        accept_s   = in_valid_i && in_ready_r;
        drain_s    = !out_valid_r || out_ready_i;
        complete_s = (cnt_r == CNT_LAST) || in_last_i;
        lane_s     = lane_idx(lane_t'(cnt_r), BIG_ENDIAN, LAST_LANE);
        for (int l = 0; l < WORD_BYTES; l++) begin
            lane_hit_s[l] = (lane_t'(l) == lane_s);
        end
    end

    // Accumulator, pending-word and output-register next-state logic.
    always_comb begin
        acc_s       = acc_r;
        acc_keep_s  = acc_keep_r;
        acc_last_s  = acc_last_r;
        acc_full_s  = acc_full_r;
        cnt_s       = cnt_r;
        out_data_s  = out_data_r;
        out_keep_s  = out_keep_r;
        out_last_s  = out_last_r;
        out_valid_s = out_valid_r && !out_ready_i;
        slot_free_s = drain_s;

        // A parked word takes the output slot first and frees the accumulator.
        if (acc_full_r && drain_s) begin
            out_data_s  = acc_r;
            out_keep_s  = acc_keep_r;
            out_last_s  = acc_last_r;
            out_valid_s = 1'b1;
            acc_s       = '0;
            acc_keep_s  = '0;
            acc_last_s  = 1'b0;
            acc_full_s  = 1'b0;
            slot_free_s = 1'b0;
        end else begin
            slot_free_s = drain_s;
        end

        // Merge the incoming byte into whatever the accumulator holds after the move above.
        for (int l = 0; l < WORD_BYTES; l++) begin
            word_s[l*BYTE_W +: BYTE_W] = lane_hit_s[l] ? in_data_i : acc_s[l*BYTE_W +: BYTE_W];
        end
        word_keep_s = acc_keep_s | lane_hit_s;

        if (accept_s) begin
            if (complete_s) begin
                cnt_s = '0;
                if (slot_free_s) begin
                    out_data_s  = word_s;
                    out_keep_s  = word_keep_s;
                    out_last_s  = in_last_i;
                    out_valid_s = 1'b1;
                    acc_s       = '0;
                    acc_keep_s  = '0;
                    acc_last_s  = 1'b0;
                end else begin
                    acc_s      = word_s;
                    acc_keep_s = word_keep_s;
                    acc_last_s = in_last_i;
                    acc_full_s = 1'b1;
                end
            end else begin
                acc_s      = word_s;
                acc_keep_s = word_keep_s;
                cnt_s      = cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_s = cnt_r;
        end
    end

    // State registers; reset discards any partial word and reopens the input.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            acc_r       <= '0;
            acc_keep_r  <= '0;
            acc_last_r  <= 1'b0;
            acc_full_r  <= 1'b0;
            cnt_r       <= '0;
            out_data_r  <= '0;
            out_keep_r  <= '0;
            out_last_r  <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            acc_r       <= acc_s;
            acc_keep_r  <= acc_keep_s;
            acc_last_r  <= acc_last_s;
            acc_full_r  <= acc_full_s;
            cnt_r       <= cnt_s;
            out_data_r  <= out_data_s;
            out_keep_r  <= out_keep_s;
            out_last_r  <= out_last_s;
            out_valid_r <= out_valid_s;
            in_ready_r  <= !acc_full_s;
        end
    end

endmodule

// File: tb/tb_byte_word_packer.sv
// Self-checking bench: a big-endian and a little-endian packer share one stimulus stream;
// a reference model queues the expected words and a monitor checks each output transfer.
module tb_byte_word_packer;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } word_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        out_ready;

    logic        be_in_ready, be_out_valid, be_out_last;
    logic [31:0] be_out_data;
    logic [3:0]  be_out_keep;
    logic        le_in_ready, le_out_valid, le_out_last;
    logic [31:0] le_out_data;
    logic [3:0]  le_out_keep;

    word_t      q_be[$];
    word_t      q_le[$];
    logic [7:0] cur[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    // Free-running clock.
    always #5 clk = ~clk;

    byte_word_packer #(.WORD_BYTES(4), .BIG_ENDIAN(1'b1)) u_be (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid), .in_ready_o(be_in_ready), .in_data_i(in_data), .in_last_i(in_last),
        .out_valid_o(be_out_valid), .out_ready_i(out_ready), .out_data_o(be_out_data),
        .out_keep_o(be_out_keep), .out_last_o(be_out_last)
    );

    byte_word_packer #(.WORD_BYTES(4), .BIG_ENDIAN(1'b0)) u_le (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid), .in_ready_o(le_in_ready), .in_data_i(in_data), .in_last_i(in_last),
        .out_valid_o(le_out_valid), .out_ready_i(out_ready), .out_data_o(le_out_data),
        .out_keep_o(le_out_keep), .out_last_o(le_out_last)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: collect bytes, build both lane orders when a word closes.
    task automatic model_push(input logic [7:0] b, input logic last);
        word_t wb;
        word_t wl;
        cur.push_back(b);
        if (cur.size() == 4 || last) begin
            wb = '0;
            wl = '0;
            for (int k = 0; k < cur.size(); k++) begin
                wb.data[(3-k)*8 +: 8] = cur[k];
                wb.keep[3-k]          = 1'b1;
                wl.data[k*8 +: 8]     = cur[k];
                wl.keep[k]            = 1'b1;
            end
            wb.last = last;
            wl.last = last;
            q_be.push_back(wb);
            q_le.push_back(wl);
            cur.delete();
        end
    endtask

    // Offer one byte, wait (bounded) for ready, complete the transfer; returns #1 after the edge.
    task automatic send_byte(input logic [7:0] b, input logic last);
        int budget;
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        budget   = 0;
        while (!(be_in_ready && le_in_ready)) begin
            @(posedge clk);
            #1;
            budget++;
            if (budget > 50) begin
                check("in_ready_timeout", 64'd0, 64'd1);
                in_valid = 1'b0;
                return;
            end
        end
        model_push(b, last);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Output monitor: every accepted word is compared against the model queue.
    always @(negedge clk) begin
        word_t w;
        if (rst_n && out_ready) begin
            if (be_out_valid) begin
                if (q_be.size() == 0) begin
                    check("be_unexpected_word", 64'd1, 64'd0);
                end else begin
                    w = q_be.pop_front();
                    check("be_word_data", 64'(be_out_data), 64'(w.data));
                    check("be_word_keep", 64'(be_out_keep), 64'(w.keep));
                    check("be_word_last", 64'(be_out_last), 64'(w.last));
                end
            end
            if (le_out_valid) begin
                if (q_le.size() == 0) begin
                    check("le_unexpected_word", 64'd1, 64'd0);
                end else begin
                    w = q_le.pop_front();
                    check("le_word_data", 64'(le_out_data), 64'(w.data));
                    check("le_word_keep", 64'(le_out_keep), 64'(w.keep));
                    check("le_word_last", 64'(le_out_last), 64'(w.last));
                end
            end
        end
    end

    initial begin
        int budget;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check("rst_out_valid", 64'(be_out_valid), 64'd0);
        check("rst_out_data",  64'(be_out_data),  64'd0);
        check("rst_out_keep",  64'(be_out_keep),  64'd0);
        check("rst_out_last",  64'(be_out_last),  64'd0);
        check("rst_in_ready",  64'(be_in_ready),  64'd1);
        check("rst_le_valid",  64'(le_out_valid), 64'd0);
        rst_n = 1'b1;
        idle(1);

        // Full word, both lane orders, one-cycle latency
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        check("t1_no_early_valid", 64'(be_out_valid), 64'd0);
        send_byte(8'h44, 1'b0);
        check("t1_be_valid", 64'(be_out_valid), 64'd1);
        check("t1_be_data",  64'(be_out_data),  64'h11223344);
        check("t1_be_keep",  64'(be_out_keep),  64'b1111);
        check("t1_be_last",  64'(be_out_last),  64'd0);
        check("t2_le_data",  64'(le_out_data),  64'h44332211);
        check("t2_le_keep",  64'(le_out_keep),  64'b1111);
        idle(2);
        check("t1_valid_drops", 64'(be_out_valid), 64'd0);

        // Partial word closed by last
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b1);
        check("t3_be_data", 64'(be_out_data), 64'hAABB0000);
        check("t3_be_keep", 64'(be_out_keep), 64'b1100);
        check("t3_be_last", 64'(be_out_last), 64'd1);
        check("t3_le_data", 64'(le_out_data), 64'h0000BBAA);
        check("t3_le_keep", 64'(le_out_keep), 64'b0011);
        check("t3_le_last", 64'(le_out_last), 64'd1);
        idle(1);

        // Single-byte packet
        send_byte(8'hCC, 1'b1);
        check("t3s_be_data", 64'(be_out_data), 64'hCC000000);
        check("t3s_be_keep", 64'(be_out_keep), 64'b1000);
        check("t3s_le_keep", 64'(le_out_keep), 64'b0001);
        idle(2);

        // Back-pressure: second word parks, input stalls, both drain in order
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b0);
        check("t4_w1_valid", 64'(be_out_valid), 64'd1);
        check("t4_w1_data",  64'(be_out_data),  64'h01020304);
        for (int i = 5; i <= 8; i++) send_byte(8'(i), 1'b0);
        check("t4_in_ready_low", 64'(be_in_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            check("t4_hold_data",  64'(be_out_data),  64'h01020304);
            check("t4_hold_valid", 64'(be_out_valid), 64'd1);
            check("t4_hold_ready", 64'(be_in_ready),  64'd0);
        end
        out_ready = 1'b1;
        idle(1);
        check("t4_w2_data",     64'(be_out_data),  64'h05060708);
        check("t4_w2_valid",    64'(be_out_valid), 64'd1);
        check("t4_ready_again", 64'(be_in_ready),  64'd1);
        idle(2);
        check("t4_drained_valid", 64'(be_out_valid), 64'd0);
        check("t4_queue_empty",   64'(q_be.size()),  64'd0);

        // Reset in the middle of a word
        send_byte(8'h5A, 1'b0);
        send_byte(8'h6B, 1'b0);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        cur.delete();
        check("t5_out_valid", 64'(be_out_valid), 64'd0);
        check("t5_out_data",  64'(be_out_data),  64'd0);
        check("t5_out_keep",  64'(be_out_keep),  64'd0);
        check("t5_in_ready",  64'(be_in_ready),  64'd1);
        rst_n = 1'b1;
        idle(1);
        send_byte(8'hA1, 1'b0);
        send_byte(8'hA2, 1'b0);
        send_byte(8'hA3, 1'b0);
        send_byte(8'hA4, 1'b0);
        check("t5_fresh_data", 64'(be_out_data), 64'hA1A2A3A4);
        check("t5_fresh_keep", 64'(be_out_keep), 64'b1111);
        idle(2);

        // Sixteen bytes back-to-back at full rate
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(8'h40 + i), 1'b0);
            check("t6_in_ready", 64'(be_in_ready), 64'd1);
            if (i % 4 == 3) begin
                check("t6_word_valid", 64'(be_out_valid), 64'd1);
            end
        end
        idle(3);

        // Every expected word must have been seen
        budget = 0;
        while ((q_be.size() != 0 || q_le.size() != 0) && budget < 20) begin
            idle(1);
            budget++;
        end
        check("end_be_queue", 64'(q_be.size()), 64'd0);
        check("end_le_queue", 64'(q_le.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
